// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//   Parametrised serial bit-pattern detector. Bits are shifted in one per
//   qualified clock (en=1). A registered one-cycle pulse on `out` flags each
//   occurrence of PATTERN, and a saturating counter tallies matches since the
//   last reset or clear. The next-state table is a KMP-style automaton that is
//   computed once at elaboration from PATTERN, so no pattern storage exists at
//   run time.
//
// Parameters
//   LEN      pattern length in bits, 2..32
//   PATTERN  pattern; PATTERN[LEN-1] is the first bit received
//   OVERLAP  1 = a match may reuse the tail of the previous occurrence
//   CNT_W    match counter width
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   en         in   1      signal carries a valid bit this cycle
//   clr        in   1      synchronous clear of state, out and match_cnt
//   signal     in   1      serial data bit
//   out        out  1      registered match pulse
//   match_cnt  out  CNT_W  saturating match count
// ---------------------------------------------------------------------------
module seq_detect_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             signal,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    if (LEN < 2 || LEN > 32) begin : g_len_err
        $error("seq_detect_param: LEN must lie in 2..32");
    end

    localparam int            SW   = $clog2(LEN);
    localparam int            NS   = 1 << SW;
    localparam logic [SW-1:0] LAST = SW'(LEN - 1);

    // i-th pattern bit in arrival order (i = 0 is the first bit received).
    function automatic logic pbit(input int i);
        logic [63:0] p;
        p = 64'(PATTERN) >> (LEN - 1 - i);
        return p[0];
    endfunction

    function automatic logic [63:0] low_mask(input int k);
        return (64'd1 << k) - 64'd1;
    endfunction

    // State reached from state s on bit b. The recent history is exactly the
    // first s pattern bits followed by b, so the new state is the longest
    // suffix of that short sequence which is also a proper prefix of PATTERN.
    // A full match in non-overlapping mode restarts from zero.
    function automatic int next_st(input int s, input logic b);
        logic [63:0] seq;
        int          n;
        int          kmax;
        int          res;
        bit          found;
        seq = '0;
        for (int i = 0; i < s; i++) seq = {seq[62:0], pbit(i)};
        seq   = {seq[62:0], b};
        n     = s + 1;
        kmax  = (n < LEN) ? n : LEN - 1;
        res   = 0;
        found = 1'b0;
        if (!(n == LEN && b == pbit(s) && !OVERLAP)) begin
            for (int k = kmax; k > 0; k--) begin
                if (!found && (seq & low_mask(k)) == (64'(PATTERN) >> (LEN - k))) begin
                    res   = k;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Elaboration-time transition and expected-bit tables. Codes at or above
    // LEN cannot be reached; they are filled with zero so indexing by the full
    // state width stays in range.
    logic [SW-1:0] nxt0 [NS];
    logic [SW-1:0] nxt1 [NS];
    logic [NS-1:0] exp_bit;

    for (genvar s = 0; s < NS; s++) begin : g_tab
        if (s < LEN) begin : g_live
            localparam logic [SW-1:0] N0 = SW'(next_st(s, 1'b0));
            localparam logic [SW-1:0] N1 = SW'(next_st(s, 1'b1));
            localparam logic          EB = pbit(s);
            assign nxt0[s]    = N0;
            assign nxt1[s]    = N1;
            assign exp_bit[s] = EB;
        end else begin : g_dead
            assign nxt0[s]    = '0;
            assign nxt1[s]    = '0;
            assign exp_bit[s] = 1'b0;
        end
    end

    // The state is a matched-prefix length rather than a set of named modes,
    // so it is kept as a plain count instead of an enum.
    logic [SW-1:0]    st, st_d;
    logic             out_d;
    logic [CNT_W-1:0] cnt_d;
    logic             hit;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        st_d  = st;
        out_d = 1'b0;
        cnt_d = match_cnt;
        hit   = en && (st == LAST) && (signal == exp_bit[st]);
        if (clr) begin
            st_d  = '0;
            cnt_d = '0;
        end else if (en) begin
            st_d  = signal ? nxt1[st] : nxt0[st];
            out_d = hit;
            if (hit && match_cnt != '1) cnt_d = match_cnt + 1'b1;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= '0;
            out       <= 1'b0;
            match_cnt <= '0;
        end else begin
            st        <= st_d;
            out       <= out_d;
            match_cnt <= cnt_d;
        end
    end

endmodule
